// File: rtl/branch_ctrl.sv
// Branch resolution unit: evaluates the condition for a candidate branch against the ALU flags,
// emits a one-cycle taken pulse with its target, then holds the front end in a fixed-length flush.
module branch_ctrl #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] offset,
    input  logic             flag_we,
    input  logic             zero_in,
    input  logic             neg_in,
    output logic             taken,
    output logic [WIDTH-1:0] target,
    output logic             flush,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [3:0]       fcnt_reg, fcnt_next;
    logic             z_reg, n_reg;
    logic             taken_reg;
    logic [WIDTH-1:0] target_reg;
    logic [CNT_W-1:0] count_reg;

    logic eff_z, eff_n, cond, branch;

    // Flags written this cycle are bypassed so a compare-and-branch pair resolves without a stall.
    always_comb begin
        eff_z = flag_we ? zero_in : z_reg;
        eff_n = flag_we ? neg_in  : n_reg;
        cond  = 1'b0;
        case (opcode)
            4'b0001: cond = 1'b1;
            4'b0110: cond = eff_z;
            4'b0111: cond = !eff_z;
            4'b0100: cond = !eff_z && !eff_n;
            4'b0101: cond = eff_n;
            4'b0010: cond = !eff_n;
            4'b0011: cond = eff_z || eff_n;
            default: cond = 1'b0;
        endcase
        branch = in_valid && (state_reg == IDLE) && cond;
    end

    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        case (state_reg)
            IDLE: begin
                if (branch) begin
                    state_next = FLUSH;
                    fcnt_next  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    fcnt_next = fcnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                fcnt_next  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            fcnt_reg   <= 4'd0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            taken_reg  <= 1'b0;
            target_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            taken_reg <= branch;
            if (flag_we) begin
                z_reg <= zero_in;
                n_reg <= neg_in;
            end
            if (branch) begin
                target_reg <= pc + offset;
                if (count_reg != {CNT_W{1'b1}}) begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end
    end

    // flush decodes straight from the state register so reset clears it without waiting for an edge.
    assign in_ready    = (state_reg == IDLE);
    assign flush       = (state_reg == FLUSH);
    assign taken       = taken_reg;
    assign target      = target_reg;
    assign taken_count = count_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: two instances (flush 2 / 8-bit count, flush 3 / 2-bit count) share stimulus
// and are checked against a remaining-flush-cycles model plus directed vectors.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [15:0] pc = 16'd0;
    logic [15:0] offset = 16'd0;
    logic        flag_we = 1'b0;
    logic        zero_in = 1'b0;
    logic        neg_in = 1'b0;

    logic        in_ready0, taken0, flush0;
    logic [15:0] target0;
    logic [7:0]  count0;
    logic        in_ready1, taken1, flush1;
    logic [15:0] target1;
    logic [1:0]  count1;

    int total = 0;
    int bad = 0;

    branch_ctrl #(.WIDTH(16), .FLUSH_CYCLES(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .opcode(opcode),
        .pc(pc), .offset(offset), .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
        .taken(taken0), .target(target0), .flush(flush0), .taken_count(count0)
    );

    branch_ctrl #(.WIDTH(16), .FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .opcode(opcode),
        .pc(pc), .offset(offset), .flag_we(flag_we), .zero_in(zero_in), .neg_in(neg_in),
        .taken(taken1), .target(target1), .flush(flush1), .taken_count(count1)
    );

    always #5 clk = ~clk;

    // Reference model: each instance tracks how many flush cycles remain, starting with the current one.
    int          fc[2]   = '{2, 3};
    int          cmax[2] = '{255, 3};
    int          fl[2];
    int          cnt[2];
    logic [15:0] mtgt[2];
    logic        mtk[2];
    logic        mz, mn;

    function automatic logic cond_of(input logic [3:0] op, input logic z, input logic n);
        case (op)
            4'b0001: return 1'b1;
            4'b0110: return z;
            4'b0111: return !z;
            4'b0100: return !z && !n;
            4'b0101: return n;
            4'b0010: return !n;
            4'b0011: return z || n;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            fl[i] = 0; cnt[i] = 0; mtgt[i] = 16'd0; mtk[i] = 1'b0;
        end
        mz = 1'b0; mn = 1'b0;
    endtask

    task automatic model_edge();
        logic c;
        c = cond_of(opcode, flag_we ? zero_in : mz, flag_we ? neg_in : mn);
        for (int i = 0; i < 2; i++) begin
            if (fl[i] == 0 && in_valid && c) begin
                fl[i]   = fc[i];
                mtk[i]  = 1'b1;
                mtgt[i] = 16'((32'(pc) + 32'(offset)) % 65536);
                if (cnt[i] < cmax[i]) cnt[i]++;
            end else begin
                mtk[i] = 1'b0;
                if (fl[i] > 0) fl[i]--;
            end
        end
        if (flag_we) begin
            mz = zero_in; mn = neg_in;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("taken0", 32'(taken0), 32'(mtk[0]));
        chk("target0", 32'(target0), 32'(mtgt[0]));
        chk("flush0", 32'(flush0), 32'(fl[0] > 0));
        chk("ready0", 32'(in_ready0), 32'(fl[0] == 0));
        chk("count0", 32'(count0), 32'(cnt[0]));
        chk("taken1", 32'(taken1), 32'(mtk[1]));
        chk("target1", 32'(target1), 32'(mtgt[1]));
        chk("flush1", 32'(flush1), 32'(fl[1] > 0));
        chk("ready1", 32'(in_ready1), 32'(fl[1] == 0));
        chk("count1", 32'(count1), 32'(cnt[1]));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk_model();
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flag_we = 1'b0; opcode = 4'd0;
    endtask

    // Reset is raised between edges so its asynchronous effect is checked before any clock arrives.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        chk("rst_flush0", 32'(flush0), 32'd0);
        chk("rst_flush1", 32'(flush1), 32'd0);
        chk("rst_taken0", 32'(taken0), 32'd0);
        chk("rst_count1", 32'(count1), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_model();
    endtask

    typedef struct {
        logic        we, z, n;
        logic [3:0]  op;
        logic [15:0] pc, off;
        logic        exp_taken;
        logic [15:0] exp_target;
    } vec_t;

    vec_t vecs[13];
    int   exp_cnt35[5] = '{1, 2, 3, 3, 3};

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 4'b0110, 16'h0010, 16'h0004, 1'b1, 16'h0014};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'b0100, 16'h0020, 16'h0004, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 16'h0100, 16'h0020, 1'b1, 16'h0120};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 16'h0100, 16'h0020, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 16'hFFFE, 16'h0004, 1'b1, 16'h0002};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0001, 16'h0010, 16'hFFF0, 1'b1, 16'h0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'b0110, 16'h0500, 16'h0001, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0111, 16'h1000, 16'h0002, 1'b1, 16'h1002};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'b0011, 16'h2000, 16'h8000, 1'b1, 16'hA000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b0010, 16'h3000, 16'h0001, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'b0010, 16'h0003, 16'h0005, 1'b1, 16'h0008};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0100, 16'h0010, 16'h0010, 1'b1, 16'h0020};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0000, 16'h0010, 16'h0010, 1'b0, 16'h0000};

        model_reset();
        #2;
        do_reset();

        // Directed condition/target vectors, each applied from IDLE and drained afterwards.
        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = vecs[v].op; pc = vecs[v].pc; offset = vecs[v].off;
            flag_we = vecs[v].we; zero_in = vecs[v].z; neg_in = vecs[v].n;
            step();
            chk($sformatf("vec%0d_taken", v), 32'(taken0), 32'(vecs[v].exp_taken));
            chk($sformatf("vec%0d_taken1", v), 32'(taken1), 32'(vecs[v].exp_taken));
            if (vecs[v].exp_taken) begin
                chk($sformatf("vec%0d_target", v), 32'(target0), 32'(vecs[v].exp_target));
                chk($sformatf("vec%0d_flush", v), 32'(flush0), 32'd1);
                chk($sformatf("vec%0d_ready", v), 32'(in_ready0), 32'd0);
            end
            idle_inputs();
            for (int k = 0; k < 4; k++) step();
        end

        // Back-to-back jmp: pulse spacing is flush length plus one.
        do_reset();
        in_valid = 1'b1; opcode = 4'b0001; pc = 16'h0040; offset = 16'h0008;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("b2b0_k%0d", k), 32'(taken0), 32'(k % 3 == 0));
            chk($sformatf("b2b1_k%0d", k), 32'(taken1), 32'(k % 4 == 0));
        end
        chk("b2b_count0", 32'(count0), 32'd6);
        idle_inputs();
        for (int k = 0; k < 4; k++) step();

        // Two-bit counter saturates at three.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; opcode = 4'b0001;
            step();
            chk($sformatf("sat_k%0d", k), 32'(count1), 32'(exp_cnt35[k]));
            idle_inputs();
            for (int j = 0; j < 4; j++) step();
        end

        // Reset in the second flush cycle aborts the flush; the next jmp then goes through.
        do_reset();
        in_valid = 1'b1; opcode = 4'b0001; pc = 16'h0100; offset = 16'h0010;
        step();
        idle_inputs();
        step();
        chk("abort_pre_flush0", 32'(flush0), 32'd1);
        do_reset();
        chk("abort_ready0", 32'(in_ready0), 32'd1);
        chk("abort_count0", 32'(count0), 32'd0);
        in_valid = 1'b1; opcode = 4'b0001; pc = 16'h0200; offset = 16'h0002;
        step();
        chk("abort_next_taken", 32'(taken0), 32'd1);
        chk("abort_next_target", 32'(target0), 32'h0202);
        idle_inputs();
        for (int k = 0; k < 4; k++) step();

        // Random traffic, with an occasional reset.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            in_valid = 1'($urandom_range(0, 1));
            opcode   = 4'($urandom_range(0, 15));
            pc       = 16'($urandom);
            offset   = 16'($urandom);
            flag_we  = 1'($urandom_range(0, 2) == 0);
            zero_in  = 1'($urandom_range(0, 1));
            neg_in   = 1'($urandom_range(0, 1));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
